// File: rtl/mac_dot_accumulate.sv
// mac_dot_accumulate: LANES-wide signed dot product per beat, plus a
// per-sequence offset C, accumulated over beats framed by accFirst/accLast.
// Pipeline: INPUT_REG_DEPTH input stages, MULT_PIPE_DEPTH product stages,
// then one accumulate/output register (latency L = sum + 1).
// Optional feature macro: MAC_SATURATE_EN (clamp RES to OUT_WIDTH, flag overflow).
module mac_dot_accumulate #(
    parameter int LANES           = 4,
    parameter int IN_M_WIDTH      = 10,
    parameter int IN_A_WIDTH      = 20,
    parameter int ACC_WIDTH       = 32,
    parameter int OUT_WIDTH       = 24,
    parameter int INPUT_REG_DEPTH = 0,
    parameter int MULT_PIPE_DEPTH = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        inReady,
    input  logic [LANES*IN_M_WIDTH-1:0] A,
    input  logic [LANES*IN_M_WIDTH-1:0] B,
    input  logic [IN_A_WIDTH-1:0]       C,
    input  logic                        accFirst,
    input  logic                        accLast,
    output logic                        outReady,
    output logic [OUT_WIDTH-1:0]        RES,
    output logic                        earlyOutReady,
    output logic                        overflow
);
    localparam int VW = LANES * IN_M_WIDTH;
    localparam int IW = 2 * VW + IN_A_WIDTH + 3;
    localparam int MW = ACC_WIDTH + IN_A_WIDTH + 3;

    // Whole beat (valid, flags, C, B, A) travels as one bus so nothing skews.
    logic [IW-1:0] in_bus, in_q;
    assign in_bus = {inReady, accFirst, accLast, C, B, A};

    generate
        if (INPUT_REG_DEPTH == 0) begin : g_in_wire
            assign in_q = in_bus;
        end else begin : g_in_reg
            logic [INPUT_REG_DEPTH-1:0][IW-1:0] r;
            // Input delay line; reset clears the valid bits with everything else.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r <= '0;
                end else if (enable) begin
                    r[0] <= in_bus;
                    for (int k = 1; k < INPUT_REG_DEPTH; k++) r[k] <= r[k-1];
                end
            end
            assign in_q = r[INPUT_REG_DEPTH-1];
        end
    endgenerate

    logic [VW-1:0]         a_q, b_q;
    logic [IN_A_WIDTH-1:0] c_q;
    logic                  v_q, f_q, l_q;
    assign {v_q, f_q, l_q, c_q, b_q, a_q} = in_q;

    // Dot product: every lane is sign-extended to ACC_WIDTH, which is wide
    // enough that neither products nor the tree sum can wrap.
    logic signed [ACC_WIDTH-1:0] dot;
    always_comb begin
        dot = '0;
        for (int i = 0; i < LANES; i++)
            dot = dot + ACC_WIDTH'($signed(a_q[i*IN_M_WIDTH +: IN_M_WIDTH]))
                      * ACC_WIDTH'($signed(b_q[i*IN_M_WIDTH +: IN_M_WIDTH]));
    end

    logic [MW-1:0] m_bus, m_q;
    assign m_bus = {v_q, f_q, l_q, c_q, dot};

    generate
        if (MULT_PIPE_DEPTH == 0) begin : g_mul_wire
            assign m_q = m_bus;
        end else begin : g_mul_reg
            logic [MULT_PIPE_DEPTH-1:0][MW-1:0] r;
            // Product pipeline carrying C and flags alongside the sum.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r <= '0;
                end else if (enable) begin
                    r[0] <= m_bus;
                    for (int k = 1; k < MULT_PIPE_DEPTH; k++) r[k] <= r[k-1];
                end
            end
            assign m_q = r[MULT_PIPE_DEPTH-1];
        end
    endgenerate

    logic [ACC_WIDTH-1:0]  m_p;
    logic [IN_A_WIDTH-1:0] m_c;
    logic                  m_v, m_f, m_l, out_last;
    assign {m_v, m_f, m_l, m_c, m_p} = m_q;
    assign out_last = m_v & m_l;

    // Stage L-1 view of a finishing beat; combinational from inputs when L=1.
    assign earlyOutReady = out_last;

    logic [ACC_WIDTH-1:0] acc, acc_next;
    // First beat restarts from C, others add onto the held acc (wraps).
    always_comb begin
        acc_next = m_f ? ACC_WIDTH'($signed(m_c)) + m_p : acc + m_p;
    end

    logic [OUT_WIDTH-1:0] res_next;
`ifdef MAC_SATURATE_EN
    logic [ACC_WIDTH-OUT_WIDTH:0] hi_bits;
    logic                         sat;
    assign hi_bits = acc_next[ACC_WIDTH-1:OUT_WIDTH-1];
    // In range only if all bits above the output sign bit match it.
    assign sat = !((&hi_bits) || !(|hi_bits));
    assign res_next = !sat ? acc_next[OUT_WIDTH-1:0] :
                      acc_next[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                            : {1'b0, {(OUT_WIDTH-1){1'b1}}};

    // Overflow flag accompanies the outReady pulse it belongs to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      overflow <= 1'b0;
        else if (enable) overflow <= out_last & sat;
    end
`else
    assign res_next = acc_next[OUT_WIDTH-1:0];
    assign overflow = 1'b0;
`endif

    // Accumulator and output register; RES only moves on accLast beats.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            RES      <= '0;
            outReady <= 1'b0;
        end else if (enable) begin
            outReady <= out_last;
            if (m_v)      acc <= acc_next;
            if (out_last) RES <= res_next;
        end
    end
endmodule

// File: tb/tb_mac_dot_accumulate.sv
// Directed bench for mac_dot_accumulate at default parameters (L=2).
module tb_mac_dot_accumulate;
    logic        clk = 1'b0;
    logic        reset, enable, inReady, accFirst, accLast;
    logic [39:0] A, B;
    logic [19:0] C;
    logic        outReady, earlyOutReady, overflow;
    logic [23:0] RES;
    int          n_cmp = 0;
    int          n_bad = 0;

    mac_dot_accumulate dut (
        .clk(clk), .reset(reset), .enable(enable), .inReady(inReady),
        .A(A), .B(B), .C(C), .accFirst(accFirst), .accLast(accLast),
        .outReady(outReady), .RES(RES), .earlyOutReady(earlyOutReady),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] pk(input int v0, v1, v2, v3);
        pk = {10'(v3), 10'(v2), 10'(v1), 10'(v0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, f, l, input logic [39:0] a, b, input int c);
        inReady = v; accFirst = f; accLast = l; A = a; B = b; C = 20'(c);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 0);
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b1; idle();
        #3;
        n_cmp++; if ($signed(RES) !== 0) begin n_bad++; $display("FAIL reset_res got %0d want 0", $signed(RES)); end
        n_cmp++; if (outReady !== 1'b0) begin n_bad++; $display("FAIL reset_outready got %b want 0", outReady); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %b want 0", overflow); end
        n_cmp++; if (earlyOutReady !== 1'b0) begin n_bad++; $display("FAIL reset_early got %b want 0", earlyOutReady); end
        tick(); tick();
        reset = 1'b1;
    endtask

    task automatic test_single_shot();
        drive(1, 1, 1, pk(1, 2, 3, 4), pk(5, 6, 7, 8), 10);
        tick(); idle();
        n_cmp++; if (earlyOutReady !== 1'b1) begin n_bad++; $display("FAIL ss_early got %b want 1", earlyOutReady); end
        n_cmp++; if (outReady !== 1'b0) begin n_bad++; $display("FAIL ss_outready_early got %b want 0", outReady); end
        tick();
        n_cmp++; if (outReady !== 1'b1) begin n_bad++; $display("FAIL ss_outready got %b want 1", outReady); end
        n_cmp++; if ($signed(RES) !== 80) begin n_bad++; $display("FAIL ss_res got %0d want 80", $signed(RES)); end
        n_cmp++; if (earlyOutReady !== 1'b0) begin n_bad++; $display("FAIL ss_early_after got %b want 0", earlyOutReady); end
        tick();
        n_cmp++; if (outReady !== 1'b0) begin n_bad++; $display("FAIL ss_pulse_width got %b want 0", outReady); end
        n_cmp++; if ($signed(RES) !== 80) begin n_bad++; $display("FAIL ss_res_hold got %0d want 80", $signed(RES)); end
    endtask

    task automatic test_accumulate();
        drive(1, 1, 0, pk(1, 1, 1, 1), pk(2, 2, 2, 2), 100);
        tick(); drive(1, 0, 0, pk(1, 1, 1, 1), pk(2, 2, 2, 2), 555);
        tick(); drive(1, 0, 1, pk(1, 1, 1, 1), pk(2, 2, 2, 2), 777);
        n_cmp++; if (outReady !== 1'b0) begin n_bad++; $display("FAIL acc_beat1_out got %b want 0", outReady); end
        tick(); idle();
        n_cmp++; if (outReady !== 1'b0) begin n_bad++; $display("FAIL acc_beat2_out got %b want 0", outReady); end
        n_cmp++; if ($signed(RES) !== 80) begin n_bad++; $display("FAIL acc_res_untouched got %0d want 80", $signed(RES)); end
        tick();
        n_cmp++; if (outReady !== 1'b1) begin n_bad++; $display("FAIL acc_out got %b want 1", outReady); end
        n_cmp++; if ($signed(RES) !== 124) begin n_bad++; $display("FAIL acc_res got %0d want 124", $signed(RES)); end
        tick();
        n_cmp++; if (outReady !== 1'b0) begin n_bad++; $display("FAIL acc_single_pulse got %b want 0", outReady); end
    endtask

    task automatic test_negative();
        drive(1, 1, 1, pk(-512, -512, -512, -512), pk(511, 511, 511, 511), 0);
        tick(); idle(); tick();
        n_cmp++; if (outReady !== 1'b1) begin n_bad++; $display("FAIL neg_out got %b want 1", outReady); end
        n_cmp++; if ($signed(RES) !== -1046528) begin n_bad++; $display("FAIL neg_res got %0d want -1046528", $signed(RES)); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL neg_overflow got %b want 0", overflow); end
    endtask

    task automatic test_stall();
        drive(1, 1, 1, pk(1, 2, 3, 4), pk(5, 6, 7, 8), 10);
        tick();
        enable = 1'b0;
        drive(1, 1, 1, pk(7, 7, 7, 7), pk(9, 9, 9, 9), 5);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (outReady !== 1'b0) begin n_bad++; $display("FAIL stall_out[%0d] got %b want 0", k, outReady); end
            n_cmp++; if (earlyOutReady !== 1'b1) begin n_bad++; $display("FAIL stall_early[%0d] got %b want 1", k, earlyOutReady); end
            n_cmp++; if ($signed(RES) !== -1046528) begin n_bad++; $display("FAIL stall_res[%0d] got %0d want -1046528", k, $signed(RES)); end
        end
        enable = 1'b1; idle();
        tick();
        n_cmp++; if (outReady !== 1'b1) begin n_bad++; $display("FAIL stall_late_out got %b want 1", outReady); end
        n_cmp++; if ($signed(RES) !== 80) begin n_bad++; $display("FAIL stall_res_after got %0d want 80", $signed(RES)); end
        n_cmp++; if (earlyOutReady !== 1'b0) begin n_bad++; $display("FAIL stall_ignored_inputs got %b want 0", earlyOutReady); end
        tick();
        n_cmp++; if (outReady !== 1'b0) begin n_bad++; $display("FAIL stall_pulse_end got %b want 0", outReady); end
    endtask

    task automatic test_saturate();
`ifdef MAC_SATURATE_EN
        int  exp_res = 8388607;
        logic exp_ovf = 1'b1;
`else
        int  exp_res = -6291456;
        logic exp_ovf = 1'b0;
`endif
        for (int k = 0; k < 10; k++) begin
            drive(1, k == 0, k == 9, pk(-512, -512, -512, -512), pk(-512, -512, -512, -512), 0);
            tick();
        end
        idle(); tick();
        n_cmp++; if (outReady !== 1'b1) begin n_bad++; $display("FAIL sat_out got %b want 1", outReady); end
        n_cmp++; if ($signed(RES) !== exp_res) begin n_bad++; $display("FAIL sat_res got %0d want %0d", $signed(RES), exp_res); end
        n_cmp++; if (overflow !== exp_ovf) begin n_bad++; $display("FAIL sat_overflow got %b want %b", overflow, exp_ovf); end
        tick();
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL sat_overflow_clear got %b want 0", overflow); end
    endtask

    task automatic test_reset_mid();
        drive(1, 1, 0, pk(1, 1, 1, 1), pk(2, 2, 2, 2), 100);
        tick(); drive(1, 0, 0, pk(1, 1, 1, 1), pk(2, 2, 2, 2), 100);
        tick(); idle();
        #2 reset = 1'b0;
        #1;
        n_cmp++; if ($signed(RES) !== 0) begin n_bad++; $display("FAIL rmid_res got %0d want 0", $signed(RES)); end
        n_cmp++; if (outReady !== 1'b0) begin n_bad++; $display("FAIL rmid_out got %b want 0", outReady); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rmid_overflow got %b want 0", overflow); end
        tick();
        reset = 1'b1;
        drive(1, 0, 1, pk(1, 2, 3, 4), pk(5, 6, 7, 8), 999);
        tick(); idle();
        n_cmp++; if (earlyOutReady !== 1'b1) begin n_bad++; $display("FAIL rmid_early got %b want 1", earlyOutReady); end
        tick();
        n_cmp++; if (outReady !== 1'b1) begin n_bad++; $display("FAIL rmid_out2 got %b want 1", outReady); end
        n_cmp++; if ($signed(RES) !== 70) begin n_bad++; $display("FAIL rmid_res2 got %0d want 70", $signed(RES)); end
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_accumulate();
        test_negative();
        test_stall();
        test_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mac_dot_accumulate.md
# mac_dot_accumulate

Parametrised multiply-accumulate engine and the successor to the single-lane multiply-add. It computes a LANES-wide signed dot product per input beat, adds a per-sequence offset C, and can accumulate over an arbitrary number of beats framed by first/last flags. It has configurable input and multiplier pipelining, stall via `enable`, and optional output saturation. It is the core of the matrix-vector and FIR blocks in the linear-algebra layer.

## Interface
- `LANES`, 4: number of multiplier lanes, ≥1.
- `IN_M_WIDTH`, 10: signed width of each A/B lane.
- `IN_A_WIDTH`, 20: signed width of C.
- `ACC_WIDTH`, 32: internal accumulator width. Must be ≥ `OUT_WIDTH` and ≥ 2*`IN_M_WIDTH`+clog2(`LANES`).
- `OUT_WIDTH`, 24: signed width of RES.
- `INPUT_REG_DEPTH`, 0: register stages on A/B/C/flags, ≥0.
- `MULT_PIPE_DEPTH`, 1: product pipeline stages, 0..2.
- `clk`  in  1  the single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  global clock enable. Low freezes every register.
- `inReady`  in  1  input beat valid.
- `A`, `B`  in  LANES*IN_M_WIDTH each  packed signed lanes; lane i is bits [i*IN_M_WIDTH +: IN_M_WIDTH].
- `C`  in  IN_A_WIDTH  signed offset; used only on `accFirst` beats.
- `accFirst`, `accLast`  in  1  sequence framing; qualified by `inReady`.
- `outReady`  out  1  RES valid, one-cycle pulse per `accLast` beat.
- `RES`  out  OUT_WIDTH  signed result.
- `earlyOutReady`  out  1  asserted one enabled cycle before `outReady`.
- `overflow`  out  1  valid with `outReady`.

## Operation
- Per beat: P = Σ A_i*B_i. Each product is 2*`IN_M_WIDTH` signed. The adder tree sign-extends to `ACC_WIDTH`, and tree wrap is impossible given the width rule on `ACC_WIDTH`.
- A, B, C, `accFirst`, `accLast` and the valid bit all travel together through the pipeline. C is captured with its beat, not at output time.
- Accumulate stage, on a valid beat only: `accFirst`=1 → acc = sext(C) + P; otherwise acc = acc + P. Both wrap modulo 2^`ACC_WIDTH`.
- `accFirst`=`accLast`=1 is single-shot multiply-add.
- If a beat has `accLast`=1, RES is loaded from the new acc value and `outReady` pulses.
- Beats without `accLast` do not touch RES and do not raise `outReady`.
- `accFirst` in mid-sequence discards the running acc and restarts.
- `accLast` with no prior `accFirst` accumulates onto the held acc (0 after reset).
- Output conversion: acc is narrowed to `OUT_WIDTH`; see Configuration.
- Beats may be presented back to back every enabled cycle. No backpressure.
- `enable`=0: all pipeline, acc, RES and valid registers hold. `outReady` and `earlyOutReady` hold their levels. Inputs presented during this time are ignored.
- `reset` asserted at any time, including mid-sequence: immediately clears valid bits, acc, RES, `outReady` and `overflow` to 0. In-flight beats are lost.
- `earlyOutReady` is also cleared by reset: it is 0 when L>1, and when L=1 it is combinational from the inputs.

## Timing
- Latency L = `INPUT_REG_DEPTH` + `MULT_PIPE_DEPTH` + 1 enabled cycles, measured from the `inReady` beat to `outReady`/RES. The +1 is the accumulate/output register.
- Throughput is one beat per enabled cycle.
- `earlyOutReady` is the `accLast`-qualified valid at stage L-1. For L=1 it equals `inReady & accLast` (combinational).
- RES holds its last value between pulses.

## Configuration
- `MAC_SATURATE_EN` defined:
  - acc outside [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] clamps RES to the nearest bound.
  - `overflow`=1 with that `outReady`, else 0.
  - acc itself keeps wrap semantics in `ACC_WIDTH`.
- Not defined:
  - RES = acc[OUT_WIDTH-1:0] (two's-complement wrap).
  - `overflow` tied to 0.

## Test plan
All scenarios use defaults (L=2).
- Single-shot: A={1,2,3,4}, B={5,6,7,8}, C=10, first=last=1 → `earlyOutReady` 1 cycle later; RES=80 and `outReady` pulse 2 cycles later.
- Accumulation: 3 consecutive beats, A=all 1, B=all 2, C=100 on the first, last on the third → a single `outReady` after the third beat, RES=124.
- Negative extremes: A=all -512, B=all 511, C=0, single-shot → RES=-1046528, `overflow`=0.
- Stall: drop `enable` for 3 cycles right after a single-shot beat → `outReady` arrives exactly 3 cycles late, RES unchanged (80).
- Saturation: 10-beat sequence, A=B=all -512, C=0:
  - With `MAC_SATURATE_EN` → RES=8388607, `overflow`=1.
  - Without → RES=-6291456, `overflow`=0.
- Reset mid-sequence: reset low after 2 non-last beats → RES, `outReady` and `overflow` read 0 immediately. The next beat, single-shot with `accFirst`=0 (A={1,2,3,4}, B={5,6,7,8}, C ignored), gives RES=70.
